// File: rtl/ctrl_pkg.sv
// Shared constants for the control pipeline: opcodes, ALUOp encodings and
// bit positions of the packed per-stage control fields.
package ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;
  localparam logic [1:0] AluXor   = 2'b11;

  // ex_ctrl = {RegDst, ALUSrc, ALUOp[1:0], Branch, SignZero}
  localparam int unsigned ExRegDst   = 5;
  localparam int unsigned ExAluSrc   = 4;
  localparam int unsigned ExAluOpHi  = 3;
  localparam int unsigned ExAluOpLo  = 2;
  localparam int unsigned ExBranch   = 1;
  localparam int unsigned ExSignZero = 0;
  // mem_ctrl = {MemRead, MemWrite}
  localparam int unsigned MemRead  = 1;
  localparam int unsigned MemWrite = 0;
  // wb_ctrl = {MemtoReg, RegWrite}
  localparam int unsigned WbMemtoReg = 1;
  localparam int unsigned WbRegWrite = 0;

  typedef struct packed {
    logic [5:0] ex;
    logic [1:0] mem;
    logic [1:0] wb;
  } ctrl_t;

  function automatic logic [5:0] pack_ex(input logic reg_dst, input logic alu_src,
                                         input logic [1:0] alu_op, input logic branch,
                                         input logic sign_zero);
    logic [5:0] r;
    r                        = '0;
    r[ExRegDst]              = reg_dst;
    r[ExAluSrc]              = alu_src;
    r[ExAluOpHi:ExAluOpLo]   = alu_op;
    r[ExBranch]              = branch;
    r[ExSignZero]            = sign_zero;
    return r;
  endfunction

  function automatic logic [1:0] pack_mem(input logic mem_read, input logic mem_write);
    logic [1:0] r;
    r           = '0;
    r[MemRead]  = mem_read;
    r[MemWrite] = mem_write;
    return r;
  endfunction

  function automatic logic [1:0] pack_wb(input logic mem_to_reg, input logic reg_write);
    logic [1:0] r;
    r             = '0;
    r[WbMemtoReg] = mem_to_reg;
    r[WbRegWrite] = reg_write;
    return r;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational main-control decoder: opcode to per-stage control fields.
// Unknown opcodes decode to a bubble and raise illegal_o.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPW = 6
) (
  input  logic [OPW-1:0] opcode_i,
  output logic [5:0]     ex_o,
  output logic [1:0]     mem_o,
  output logic [1:0]     wb_o,
  output logic           jump_o,
  output logic           illegal_o
);

  always_comb begin
    ex_o      = '0;
    mem_o     = '0;
    wb_o      = '0;
    jump_o    = 1'b0;
    illegal_o = 1'b0;
    case (opcode_i)
      OPW'(OpRtype): begin
        ex_o = pack_ex(1'b1, 1'b0, AluFunct, 1'b0, 1'b0);
        wb_o = pack_wb(1'b0, 1'b1);
      end
      OPW'(OpLw): begin
        ex_o  = pack_ex(1'b0, 1'b1, AluAdd, 1'b0, 1'b0);
        mem_o = pack_mem(1'b1, 1'b0);
        wb_o  = pack_wb(1'b1, 1'b1);
      end
      OPW'(OpSw): begin
        ex_o  = pack_ex(1'b0, 1'b1, AluAdd, 1'b0, 1'b0);
        mem_o = pack_mem(1'b0, 1'b1);
      end
      OPW'(OpBne): begin
        ex_o = pack_ex(1'b0, 1'b0, AluSub, 1'b1, 1'b0);
      end
      OPW'(OpXori): begin
        ex_o = pack_ex(1'b0, 1'b1, AluXor, 1'b0, 1'b1);
        wb_o = pack_wb(1'b0, 1'b1);
      end
      OPW'(OpAddi): begin
        ex_o = pack_ex(1'b0, 1'b1, AluAdd, 1'b0, 1'b0);
        wb_o = pack_wb(1'b0, 1'b1);
      end
      OPW'(OpJ): begin
        jump_o = 1'b1;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline: decodes the ID instruction and carries its control
// through EX/MEM/WB, with load-use stall detection and flush handling.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned OPW  = 6,
  parameter int unsigned RAW  = 5,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [OPW-1:0]  id_opcode,
  input  logic [RAW-1:0]  id_rs,
  input  logic [RAW-1:0]  id_rt,
  input  logic            flush,
  output logic [5:0]      ex_ctrl,
  output logic [1:0]      mem_ctrl,
  output logic [1:0]      wb_ctrl,
  output logic            id_jump,
  output logic            stall,
  output logic            illegal,
  output logic [CNTW-1:0] stall_cnt
);

  logic [5:0] dec_ex;
  logic [1:0] dec_mem;
  logic [1:0] dec_wb;
  logic       dec_jump;
  logic       dec_illegal;

  ctrl_decode #(
    .OPW(OPW)
  ) u_decode (
    .opcode_i  (id_opcode),
    .ex_o      (dec_ex),
    .mem_o     (dec_mem),
    .wb_o      (dec_wb),
    .jump_o    (dec_jump),
    .illegal_o (dec_illegal)
  );

  ctrl_t           ex_d, ex_q;
  logic [RAW-1:0]  ex_rt_d, ex_rt_q;
  logic            illegal_d, illegal_q;
  logic [1:0]      mem_ctrl_d, mem_ctrl_q;
  logic [1:0]      mem_wb_d, mem_wb_q;
  logic [1:0]      wb_ctrl_d, wb_ctrl_q;
  logic [CNTW-1:0] stall_cnt_d, stall_cnt_q;
  logic            hazard;
  logic            issue;

  // Load in EX whose destination is read by the ID instruction; r0 never hazards.
  assign hazard = ex_q.mem[MemRead] & id_valid & (ex_rt_q != '0) &
                  ((ex_rt_q == id_rs) | (ex_rt_q == id_rt));
  assign stall   = hazard & ~flush;
  assign issue   = id_valid & ~flush & ~hazard;
  assign id_jump = id_valid & dec_jump & ~flush;

  always_comb begin
    ex_d        = '0;
    ex_rt_d     = '0;
    illegal_d   = 1'b0;
    mem_ctrl_d  = '0;
    mem_wb_d    = '0;
    wb_ctrl_d   = mem_wb_q;
    stall_cnt_d = stall_cnt_q;
    if (issue) begin
      ex_d.ex   = dec_ex;
      ex_d.mem  = dec_mem;
      ex_d.wb   = dec_wb;
      ex_rt_d   = id_rt;
      illegal_d = dec_illegal;
    end
    // Flush kills the instruction leaving EX as well as the one leaving ID.
    if (!flush) begin
      mem_ctrl_d = ex_q.mem;
      mem_wb_d   = ex_q.wb;
    end
    if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      ex_rt_q     <= '0;
      illegal_q   <= 1'b0;
      mem_ctrl_q  <= '0;
      mem_wb_q    <= '0;
      wb_ctrl_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      ex_rt_q     <= ex_rt_d;
      illegal_q   <= illegal_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_wb_q    <= mem_wb_d;
      wb_ctrl_q   <= wb_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_ctrl   = ex_q.ex;
  assign mem_ctrl  = mem_ctrl_q;
  assign wb_ctrl   = wb_ctrl_q;
  assign illegal   = illegal_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: a slot-based pipeline model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ctrl_pipe;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] XORI = 6'b001110;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic       flush = 1'b0;
  logic [5:0] id_opcode = '0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;

  logic [5:0]  ex_a, ex_b;
  logic [1:0]  mem_a, mem_b, wb_a, wb_b;
  logic        jump_a, jump_b, stall_a, stall_b, ill_a, ill_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  ctrl_pipe #(.OPW(6), .RAW(5), .CNTW(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .flush(flush), .ex_ctrl(ex_a), .mem_ctrl(mem_a),
    .wb_ctrl(wb_a), .id_jump(jump_a), .stall(stall_a), .illegal(ill_a), .stall_cnt(cnt_a)
  );

  ctrl_pipe #(.OPW(6), .RAW(5), .CNTW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .flush(flush), .ex_ctrl(ex_b), .mem_ctrl(mem_b),
    .wb_ctrl(wb_b), .id_jump(jump_b), .stall(stall_b), .illegal(ill_b), .stall_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One slot per stage (EX, MEM, WB) holding the whole decoded instruction.
  typedef struct packed {
    logic [5:0] ex;
    logic [1:0] mem;
    logic [1:0] wb;
    logic [4:0] rt;
    logic       ill;
  } slot_t;

  slot_t pipe [3] = '{default: '0};
  int    m_cnt = 0;

  function automatic slot_t decode_ref(input logic [5:0] op, input logic [4:0] rt);
    slot_t s;
    s = '0;
    s.rt = rt;
    case (op)
      R:       begin s.ex = 6'b101000; s.mem = 2'b00; s.wb = 2'b01; end
      LW:      begin s.ex = 6'b010000; s.mem = 2'b10; s.wb = 2'b11; end
      SW:      begin s.ex = 6'b010000; s.mem = 2'b01; s.wb = 2'b00; end
      BNE:     begin s.ex = 6'b000110; s.mem = 2'b00; s.wb = 2'b00; end
      XORI:    begin s.ex = 6'b011101; s.mem = 2'b00; s.wb = 2'b01; end
      ADDI:    begin s.ex = 6'b010000; s.mem = 2'b00; s.wb = 2'b01; end
      J:       begin s.ex = '0; end
      default: s.ill = 1'b1;
    endcase
    return s;
  endfunction

  function automatic logic m_hazard();
    return pipe[0].mem[1] && id_valid && (pipe[0].rt != 0) &&
           ((pipe[0].rt == id_rs) || (pipe[0].rt == id_rt));
  endfunction

  function automatic int sat(input int c, input int mx);
    return (c > mx) ? mx : c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe[0] <= '0;
      pipe[1] <= '0;
      pipe[2] <= '0;
      m_cnt   <= 0;
    end else begin
      pipe[2] <= pipe[1];
      pipe[1] <= flush ? slot_t'('0) : pipe[0];
      pipe[0] <= (id_valid && !flush && !m_hazard()) ? decode_ref(id_opcode, id_rt)
                                                     : slot_t'('0);
      if (m_hazard() && !flush) m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("cmp_ex_a", ex_a, pipe[0].ex);
      chk("cmp_mem_a", mem_a, pipe[1].mem);
      chk("cmp_wb_a", wb_a, pipe[2].wb);
      chk("cmp_ill_a", ill_a, pipe[0].ill);
      chk("cmp_stall_a", stall_a, m_hazard() && !flush);
      chk("cmp_jump_a", jump_a, id_valid && id_opcode == J && !flush);
      chk("cmp_cnt_a", cnt_a, sat(m_cnt, 65535));
      chk("cmp_ex_b", ex_b, pipe[0].ex);
      chk("cmp_mem_b", mem_b, pipe[1].mem);
      chk("cmp_wb_b", wb_b, pipe[2].wb);
      chk("cmp_stall_b", stall_b, m_hazard() && !flush);
      chk("cmp_cnt_b", cnt_b, sat(m_cnt, 3));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic fl);
    id_valid  = v;
    id_opcode = op;
    id_rs     = rs;
    id_rt     = rt;
    flush     = fl;
    #1;
  endtask

  initial begin
    logic [5:0] ops [5];
    ops = '{SW, BNE, XORI, ADDI, LW};

    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    run   = 1'b1;
    chk("rst_ex", ex_a, 6'b0);
    chk("rst_mem", mem_a, 2'b0);
    chk("rst_wb", wb_a, 2'b0);
    chk("rst_cnt", cnt_a, 16'd0);

    // R-type through the pipe
    drive(1'b1, R, 5'd1, 5'd2, 1'b0);
    tick();
    chk("r_ex", ex_a, 6'b101000);
    drive(1'b0, R, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    chk("r_wb", wb_a, 2'b01);

    // Load-use hazard
    drive(1'b1, LW, 5'd1, 5'd5, 1'b0);
    tick();
    drive(1'b1, R, 5'd5, 5'd2, 1'b0);
    chk("lu_stall", stall_a, 1'b1);
    tick();
    chk("lu_bubble", ex_a, 6'b0);
    chk("lu_cnt", cnt_a, 16'd1);
    chk("lu_mem", mem_a, 2'b10);
    chk("lu_nostall", stall_a, 1'b0);
    tick();
    chk("lu_issue", ex_a, 6'b101000);

    // Load to r0 never stalls
    drive(1'b1, LW, 5'd3, 5'd0, 1'b0);
    tick();
    drive(1'b1, R, 5'd0, 5'd0, 1'b0);
    chk("r0_stall", stall_a, 1'b0);
    tick();
    chk("r0_ex", ex_a, 6'b101000);
    chk("r0_cnt", cnt_a, 16'd1);

    // Flush beats stall
    drive(1'b1, LW, 5'd1, 5'd7, 1'b0);
    tick();
    drive(1'b1, R, 5'd7, 5'd1, 1'b1);
    chk("fl_stall", stall_a, 1'b0);
    tick();
    chk("fl_ex", ex_a, 6'b0);
    chk("fl_mem", mem_a, 2'b0);
    chk("fl_cnt", cnt_a, 16'd1);
    drive(1'b0, R, 5'd0, 5'd0, 1'b0);

    // Illegal opcode and jump
    drive(1'b1, BAD, 5'd0, 5'd0, 1'b0);
    tick();
    chk("ill_set", ill_a, 1'b1);
    chk("ill_ex", ex_a, 6'b0);
    drive(1'b0, R, 5'd0, 5'd0, 1'b0);
    tick();
    chk("ill_clr", ill_a, 1'b0);
    chk("ill_mem", mem_a, 2'b0);
    drive(1'b1, J, 5'd0, 5'd0, 1'b0);
    chk("j_jump", jump_a, 1'b1);
    drive(1'b1, J, 5'd0, 5'd0, 1'b1);
    chk("j_flush", jump_a, 1'b0);
    drive(1'b0, J, 5'd0, 5'd0, 1'b0);
    chk("j_invalid", jump_a, 1'b0);
    tick();

    // Remaining opcodes
    foreach (ops[i]) begin
      drive(1'b1, ops[i], 5'd1, 5'd2, 1'b0);
      tick();
      if (ops[i] == XORI) chk("xori_ex", ex_a, 6'b011101);
    end
    drive(1'b0, R, 5'd0, 5'd0, 1'b0);
    tick();
    tick();

    // Four more stalls: narrow counter saturates
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, LW, 5'd1, 5'd9, 1'b0);
      tick();
      drive(1'b1, R, 5'd9, 5'd0, 1'b0);
      chk("sat_stall", stall_a, 1'b1);
      tick();
    end
    chk("sat_cnt_a", cnt_a, 16'd5);
    chk("sat_cnt_b", cnt_b, 2'd3);
    drive(1'b0, R, 5'd0, 5'd0, 1'b0);

    // Reset mid-pipeline
    drive(1'b1, R, 5'd1, 5'd2, 1'b0);
    tick();
    drive(1'b1, LW, 5'd1, 5'd3, 1'b0);
    tick();
    drive(1'b1, ADDI, 5'd1, 5'd4, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mr_ex", ex_a, 6'b0);
    chk("mr_mem", mem_a, 2'b0);
    chk("mr_wb", wb_a, 2'b0);
    chk("mr_ill", ill_a, 1'b0);
    chk("mr_cnt_a", cnt_a, 16'd0);
    chk("mr_cnt_b", cnt_b, 2'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, R, 5'd1, 5'd2, 1'b0);
    tick();
    chk("mr_first", ex_a, 6'b101000);
    drive(1'b0, R, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
